sha256_wk_scheduler: RTL and testbench
======================================

Name: sha256_wk_scheduler

Overview:
Producer end of the W/K round interface: accepts one 512-bit padded message block and streams the SHA-256 message schedule W_t with round constant K_t, one round per cycle, into the hash compression round engine. It drives `cur_w`, `cur_k`, `wk_vector_index` and `wk_index_complete` exactly as the round engine consumes them, then returns to idle for the next block.

Parameters:
- WK_LENGTH, 64, number of rounds; index width is $clog2(WK_LENGTH).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- block_valid  in  1  message_block is valid
- block_ready  out  1  scheduler idle; block accepted when block_valid && block_ready
- message_block  in  512  padded block; word M0 = [511:480], M15 = [31:0]
- wk_enable  out  1  high while W/K are being issued and on the completion cycle; drives the round engine enable
- cur_w  out  32  W_t for the current round
- cur_k  out  32  K_t for the current round
- wk_vector_index  out  $clog2(WK_LENGTH)  current round t
- wk_index_complete  out  1  one-cycle pulse after round WK_LENGTH-1

Behaviour:
- One clock; reset is synchronous and active-high on `clock`/`reset`.
- Reset values: block_ready=1, wk_enable=0, cur_w=0, cur_k=0, wk_vector_index=0, wk_index_complete=0, window cleared, state=IDLE.
- Reset mid-operation aborts the block; no completion pulse.
- State machine:
  - IDLE:
    - block_ready=1.
    - On accept, load the 16-word window (win[0]=M0 .. win[15]=M15), set index=0, go to RUN.
  - RUN:
    - block_ready=0, wk_enable=1.
    - cur_w = win[0], cur_k = K[index], wk_vector_index = index. These outputs come straight from registers, with no combinational path from inputs.
    - Each cycle the window shifts down by one and win[15] takes new = σ1(win[14]) + win[9] + σ0(win[1]) + win[0], computed mod 2^32.
    - index increments each cycle. At index = WK_LENGTH-1, go to DONE next cycle.
  - DONE:
    - Lasts exactly one cycle: wk_index_complete=1, wk_enable=1, cur_w=0, cur_k=0, wk_vector_index holds WK_LENGTH-1.
    - Then go to IDLE.
- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3; σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Latency:
  - First W/K appear the cycle after the accept.
  - Block occupancy is WK_LENGTH+1 cycles.
  - block_ready reasserts the cycle after DONE.
- Any block_valid during RUN or DONE is ignored (block_ready=0); the sender holds it.
- Back-to-back blocks: a new block may be accepted on the first IDLE cycle; minimum spacing is WK_LENGTH+2 cycles.
- Index never wraps within a block; it resets to 0 on each accept.

Optional Feature:
- Macro: SHA256_WK_STALL_EN.
- Defined:
  - Adds input port wk_hold (1 bit).
  - While wk_hold=1 in RUN or DONE, all state, window, index and outputs freeze, and the completion pulse is held, not repeated.
  - A hold during IDLE has no effect.
- Undefined:
  - No wk_hold port; the block advances every cycle unconditionally.

Decomposition:
- Shared package sha256_pkg:
  - 64-entry K constant array.
  - σ0/σ1 functions (shared with the round engine's Σ/Ch/Maj).
  - State enum IDLE/RUN/DONE.
  - Word width constant 32.
- One sub-module: sha256_k_rom, a registered lookup of K[index] aligned with cur_w.

Test Plan:
- Reset, then block "abc" (M0=0x61626380, M1..M14=0, M15=0x00000018):
  - idx0: cur_w=0x61626380, cur_k=0x428a2f98.
  - idx15: cur_w=0x00000018.
  - idx16: cur_w=0x61626380.
  - idx17: cur_w=0x000F0000.
  - idx63: cur_k=0xc67178f2.
  - Then one cycle wk_index_complete=1 with cur_w=0, cur_k=0.
- Assert block_valid during RUN with a different block -> no effect on the stream; block accepted only after DONE; second stream starts at idx0 with the new M0.
- Assert reset at idx 30 -> the next cycle shows all reset values, no completion pulse, block_ready=1.
- Hold block_valid high continuously -> blocks accepted every WK_LENGTH+2 cycles; wk_index_complete pulses exactly once per block.
- (SHA256_WK_STALL_EN) Assert wk_hold for 5 cycles at idx 20 and for 2 cycles during DONE -> idx stays 20 with cur_w unchanged; the completion pulse lasts 3 cycles total; the remaining sequence is identical to the unstalled reference.
- Compare with a golden model: feed 100 random blocks and check all 64 W_t against a software SHA-256 schedule model.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type, round constants, message-schedule
// sigma functions and the W/K scheduler state encoding.
package sha256_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wk_state_t;

  localparam word_t K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t k_lookup(input logic [5:0] idx);
    return K_TABLE[idx];
  endfunction

  // sigma0 = ROTR7 ^ ROTR18 ^ SHR3
  function automatic word_t sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1 = ROTR17 ^ ROTR19 ^ SHR10
  function automatic word_t sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Registered K[t] lookup; loads the constant for the round being issued next
// so cur_k lines up with cur_w, and clears to zero when no round follows.
module sha256_k_rom
  import sha256_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             update,
  input  logic             issue,
  input  logic [IDX_W-1:0] addr,
  output word_t            k
);

  always_ff @(posedge clock) begin
    if (reset) begin
      k <= '0;
    end else if (update) begin
      k <= issue ? k_lookup(6'(addr)) : '0;
    end
  end

endmodule

// File: rtl/sha256_wk_scheduler.sv
// SHA-256 W/K producer: expands one 512-bit block into 64 schedule words plus
// round constants, one per cycle. Define SHA256_WK_STALL_EN to add wk_hold.
module sha256_wk_scheduler
  import sha256_pkg::*;
#(
  parameter int WK_LENGTH = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         block_valid,
  output logic                         block_ready,
  input  logic [511:0]                 message_block,
`ifdef SHA256_WK_STALL_EN
  input  logic                         wk_hold,
`endif
  output logic                         wk_enable,
  output logic [31:0]                  cur_w,
  output logic [31:0]                  cur_k,
  output logic [$clog2(WK_LENGTH)-1:0] wk_vector_index,
  output logic                         wk_index_complete
);

  localparam int IDX_W = $clog2(WK_LENGTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WK_LENGTH - 1);

  wk_state_t        state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  word_t            win [16];
  word_t            w_new;
  logic             hold, load, shift, rom_update, rom_issue;

`ifdef SHA256_WK_STALL_EN
  assign hold = wk_hold;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next        = state;
    idx_next          = idx;
    load              = 1'b0;
    shift             = 1'b0;
    block_ready       = 1'b0;
    wk_enable         = 1'b0;
    wk_index_complete = 1'b0;
    case (state)
      IDLE: begin
        block_ready = 1'b1;
        if (block_valid) begin
          state_next = RUN;
          idx_next   = '0;
          load       = 1'b1;
        end
      end
      RUN: begin
        wk_enable = 1'b1;
        if (!hold) begin
          shift = 1'b1;
          if (idx == LAST_IDX) state_next = DONE;
          else                 idx_next   = idx + IDX_W'(1);
        end
      end
      DONE: begin
        wk_enable         = 1'b1;
        wk_index_complete = 1'b1;
        if (!hold) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Next schedule word, appended at the top of the sliding 16-word window
  assign w_new = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) win[i] <= message_block[511 - 32*i -: 32];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= w_new;
    end
  end

  // K is fetched for the round that will be on the outputs after this edge
  assign rom_update = load || ((state != IDLE) && !hold);
  assign rom_issue  = (state_next == RUN);

  sha256_k_rom #(.IDX_W(IDX_W)) u_k_rom (
    .clock  (clock),
    .reset  (reset),
    .update (rom_update),
    .issue  (rom_issue),
    .addr   (idx_next),
    .k      (cur_k)
  );

  assign cur_w           = (state == RUN) ? win[0] : '0;
  assign wk_vector_index = idx;

endmodule

// File: tb/tb_sha256_wk_scheduler.sv
// Scoreboard bench for sha256_wk_scheduler: expected W/K/index entries are
// queued per accepted block and checked by a monitor as rounds stream out.
`timescale 1ns/1ps
module tb_sha256_wk_scheduler;

  localparam int WK_LENGTH = 64;
  localparam int IDX_W     = 6;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              block_valid = 1'b0;
  logic [511:0]      message_block = '0;
  logic              wk_hold = 1'b0;
  logic              block_ready, wk_enable, wk_index_complete;
  logic [31:0]       cur_w, cur_k;
  logic [IDX_W-1:0]  wk_vector_index;

  int n_cmp = 0;
  int n_fail = 0;
  int n_complete = 0;

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] k;
    logic [5:0]  idx;
  } exp_t;

  exp_t sb[$];

  logic [31:0] KREF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_wk_scheduler #(.WK_LENGTH(WK_LENGTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .block_valid       (block_valid),
    .block_ready       (block_ready),
    .message_block     (message_block),
`ifdef SHA256_WK_STALL_EN
    .wk_hold           (wk_hold),
`endif
    .wk_enable         (wk_enable),
    .cur_w             (cur_w),
    .cur_k             (cur_k),
    .wk_vector_index   (wk_vector_index),
    .wk_index_complete (wk_index_complete)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, need $finish before 2ms");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ms0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ms1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic push_block(input logic [511:0] blk);
    logic [31:0] w [64];
    exp_t e;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = blk[511 - 32*t -: 32];
      else        w[t] = ms1(w[t-2]) + w[t-7] + ms0(w[t-15]) + w[t-16];
      e.w = w[t];
      e.k = KREF[t];
      e.idx = 6'(t);
      sb.push_back(e);
    end
  endtask

  // Monitor: a held edge must repeat the previous outputs, otherwise pop.
  logic        hold_at_edge = 1'b0;
  logic        last_active = 1'b0;
  logic [31:0] last_w, last_k;
  logic [5:0]  last_idx;
  logic        last_cpl;
  exp_t        mon_e;

  always @(posedge clock) hold_at_edge = wk_hold;

  always @(negedge clock) begin
    if (reset) begin
      last_active = 1'b0;
    end else if (wk_enable) begin
      if (hold_at_edge && last_active) begin
        n_cmp++;
        if ({cur_w, cur_k, wk_vector_index, wk_index_complete} !== {last_w, last_k, last_idx, last_cpl}) begin
          n_fail++;
          $display("FAIL hold_freeze: got w=%h k=%h idx=%0d cpl=%b, need w=%h k=%h idx=%0d cpl=%b",
                   cur_w, cur_k, wk_vector_index, wk_index_complete, last_w, last_k, last_idx, last_cpl);
        end
      end else if (wk_index_complete) begin
        n_cmp++;
        if ({cur_w, cur_k, wk_vector_index} !== {32'h0, 32'h0, 6'd63}) begin
          n_fail++;
          $display("FAIL done_outputs: got w=%h k=%h idx=%0d, need w=0 k=0 idx=63", cur_w, cur_k, wk_vector_index);
        end
      end else if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_underflow: got round idx=%0d w=%h, need no round issued", wk_vector_index, cur_w);
      end else begin
        mon_e = sb.pop_front();
        n_cmp++;
        if ({cur_w, cur_k, wk_vector_index} !== {mon_e.w, mon_e.k, mon_e.idx}) begin
          n_fail++;
          $display("FAIL sched_round: got w=%h k=%h idx=%0d, need w=%h k=%h idx=%0d",
                   cur_w, cur_k, wk_vector_index, mon_e.w, mon_e.k, mon_e.idx);
        end
      end
      if (wk_index_complete) n_complete++;
      last_active = 1'b1;
      last_w = cur_w; last_k = cur_k; last_idx = wk_vector_index; last_cpl = wk_index_complete;
    end else begin
      last_active = 1'b0;
    end
  end

  task automatic test_reset();
    reset = 1'b1; block_valid = 1'b0; wk_hold = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({block_ready, wk_enable, cur_w, cur_k, wk_vector_index, wk_index_complete} !== {1'b1, 1'b0, 32'h0, 32'h0, 6'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b en=%b w=%h k=%h idx=%0d cpl=%b, need rdy=1 en=0 w=0 k=0 idx=0 cpl=0",
               block_ready, wk_enable, cur_w, cur_k, wk_vector_index, wk_index_complete);
    end
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({block_ready, wk_enable} !== 2'b10) begin
      n_fail++;
      $display("FAIL idle_after_reset: got rdy=%b en=%b, need rdy=1 en=0", block_ready, wk_enable);
    end
  endtask

  task automatic test_abc();
    logic [511:0] abc;
    int cpl0;
    abc = {32'h61626380, {14{32'h0}}, 32'h00000018};
    cpl0 = n_complete;
    message_block = abc; block_valid = 1'b1; push_block(abc);
    for (int c = 1; c <= 66; c++) begin
      @(negedge clock);
      n_cmp++;
      case (c)
        1: if ({block_ready, wk_enable, wk_vector_index, cur_w, cur_k} !== {1'b0, 1'b1, 6'd0, 32'h61626380, 32'h428a2f98}) begin
             n_fail++; $display("FAIL abc_idx0: got rdy=%b en=%b idx=%0d w=%h k=%h, need rdy=0 en=1 idx=0 w=61626380 k=428a2f98",
                                block_ready, wk_enable, wk_vector_index, cur_w, cur_k); end
        16: if ({wk_vector_index, cur_w} !== {6'd15, 32'h00000018}) begin
              n_fail++; $display("FAIL abc_idx15: got idx=%0d w=%h, need idx=15 w=00000018", wk_vector_index, cur_w); end
        17: if ({wk_vector_index, cur_w} !== {6'd16, 32'h61626380}) begin
              n_fail++; $display("FAIL abc_idx16: got idx=%0d w=%h, need idx=16 w=61626380", wk_vector_index, cur_w); end
        18: if ({wk_vector_index, cur_w} !== {6'd17, 32'h000F0000}) begin
              n_fail++; $display("FAIL abc_idx17: got idx=%0d w=%h, need idx=17 w=000f0000", wk_vector_index, cur_w); end
        64: if ({wk_vector_index, cur_k, wk_index_complete} !== {6'd63, 32'hc67178f2, 1'b0}) begin
              n_fail++; $display("FAIL abc_idx63: got idx=%0d k=%h cpl=%b, need idx=63 k=c67178f2 cpl=0", wk_vector_index, cur_k, wk_index_complete); end
        65: if ({wk_index_complete, wk_enable, block_ready, cur_w, cur_k, wk_vector_index} !== {1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 6'd63}) begin
              n_fail++; $display("FAIL abc_done: got cpl=%b en=%b rdy=%b w=%h k=%h idx=%0d, need cpl=1 en=1 rdy=0 w=0 k=0 idx=63",
                                 wk_index_complete, wk_enable, block_ready, cur_w, cur_k, wk_vector_index); end
        66: if ({wk_index_complete, wk_enable, block_ready} !== 3'b001) begin
              n_fail++; $display("FAIL abc_back_idle: got cpl=%b en=%b rdy=%b, need cpl=0 en=0 rdy=1", wk_index_complete, wk_enable, block_ready); end
        default: if (wk_enable !== 1'b1 || wk_index_complete !== 1'b0) begin
              n_fail++; $display("FAIL abc_run_c%0d: got en=%b cpl=%b, need en=1 cpl=0", c, wk_enable, wk_index_complete); end
      endcase
      if (c == 1) block_valid = 1'b0;
    end
    n_cmp++;
    if (n_complete - cpl0 !== 1) begin
      n_fail++; $display("FAIL abc_pulse_count: got %0d, need 1", n_complete - cpl0);
    end
  endtask

  task automatic test_ignore_valid();
    logic [511:0] a, b;
    int cpl0;
    a = rand512(); b = rand512();
    cpl0 = n_complete;
    message_block = a; block_valid = 1'b1; push_block(a);
    for (int c = 1; c <= 132; c++) begin
      @(negedge clock);
      if (c == 1) block_valid = 1'b0;
      if (c == 11) begin message_block = b; block_valid = 1'b1; push_block(b); end
      if (c == 40) begin
        n_cmp++;
        if ({block_ready, wk_vector_index} !== {1'b0, 6'd39}) begin
          n_fail++; $display("FAIL ignore_run: got rdy=%b idx=%0d, need rdy=0 idx=39", block_ready, wk_vector_index);
        end
      end
      if (c == 66) begin
        n_cmp++;
        if (block_ready !== 1'b1) begin
          n_fail++; $display("FAIL ignore_ready_first_idle: got rdy=%b, need 1", block_ready);
        end
      end
      if (c == 67) begin
        n_cmp++;
        if ({wk_enable, wk_vector_index, cur_w} !== {1'b1, 6'd0, b[511:480]}) begin
          n_fail++; $display("FAIL ignore_second_start: got en=%b idx=%0d w=%h, need en=1 idx=0 w=%h",
                             wk_enable, wk_vector_index, cur_w, b[511:480]);
        end
        block_valid = 1'b0;
      end
    end
    n_cmp++;
    if ({block_ready, n_complete - cpl0} !== {1'b1, 32'd2}) begin
      n_fail++; $display("FAIL ignore_end: got rdy=%b pulses=%0d, need rdy=1 pulses=2", block_ready, n_complete - cpl0);
    end
  endtask

  task automatic test_reset_mid();
    logic [511:0] blk;
    int cpl0;
    blk = rand512();
    message_block = blk; block_valid = 1'b1; push_block(blk);
    for (int c = 1; c <= 31; c++) begin
      @(negedge clock);
      if (c == 1) block_valid = 1'b0;
    end
    n_cmp++;
    if (wk_vector_index !== 6'd30) begin
      n_fail++; $display("FAIL rstmid_pre_idx: got %0d, need 30", wk_vector_index);
    end
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({block_ready, wk_enable, cur_w, cur_k, wk_vector_index, wk_index_complete} !== {1'b1, 1'b0, 32'h0, 32'h0, 6'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_values: got rdy=%b en=%b w=%h k=%h idx=%0d cpl=%b, need rdy=1 en=0 w=0 k=0 idx=0 cpl=0",
               block_ready, wk_enable, cur_w, cur_k, wk_vector_index, wk_index_complete);
    end
    sb.delete();
    reset = 1'b0;
    cpl0 = n_complete;
    repeat (70) @(negedge clock);
    n_cmp++;
    if ({block_ready, wk_enable, n_complete - cpl0} !== {1'b1, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL rstmid_after: got rdy=%b en=%b pulses=%0d, need rdy=1 en=0 pulses=0",
                         block_ready, wk_enable, n_complete - cpl0);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, last_acc, acc, cpl0;
    bit need_new;
    cyc = 0; last_acc = -1; acc = 0; need_new = 0;
    cpl0 = n_complete;
    message_block = rand512(); block_valid = 1'b1;
    while (cyc < 4*(WK_LENGTH+2) + 10) begin
      if (block_ready) begin
        if (acc == 3) begin block_valid = 1'b0; break; end
        if (last_acc >= 0) begin
          n_cmp++;
          if (cyc - last_acc !== WK_LENGTH + 2) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d cycles, need %0d", cyc - last_acc, WK_LENGTH + 2);
          end
        end
        push_block(message_block);
        last_acc = cyc; acc++; need_new = 1;
      end else if (need_new) begin
        message_block = rand512(); need_new = 0;
      end
      @(negedge clock); cyc++;
    end
    n_cmp++;
    if ({block_valid, acc, n_complete - cpl0} !== {1'b0, 32'd3, 32'd3}) begin
      n_fail++; $display("FAIL b2b_totals: got accepts=%0d pulses=%0d finished=%b, need accepts=3 pulses=3 finished=1",
                         acc, n_complete - cpl0, ~block_valid);
    end
    block_valid = 1'b0;
  endtask

`ifdef SHA256_WK_STALL_EN
  task automatic test_stall();
    logic [511:0] blk;
    logic [31:0] saved_w;
    int cpl0;
    blk = rand512();
    saved_w = '0;
    cpl0 = n_complete;
    message_block = blk; block_valid = 1'b1; push_block(blk);
    for (int c = 1; c <= 73; c++) begin
      @(negedge clock);
      if (c == 1) block_valid = 1'b0;
      if (c == 21) begin saved_w = cur_w; wk_hold = 1'b1; end
      if (c >= 22 && c <= 26) begin
        n_cmp++;
        if ({wk_vector_index, cur_w} !== {6'd20, saved_w}) begin
          n_fail++; $display("FAIL stall_freeze_c%0d: got idx=%0d w=%h, need idx=20 w=%h", c, wk_vector_index, cur_w, saved_w);
        end
        if (c == 26) wk_hold = 1'b0;
      end
      if (c == 27) begin
        n_cmp++;
        if (wk_vector_index !== 6'd21) begin
          n_fail++; $display("FAIL stall_resume: got idx=%0d, need 21", wk_vector_index);
        end
      end
      if (c == 70) begin
        n_cmp++;
        if (wk_index_complete !== 1'b1) begin
          n_fail++; $display("FAIL stall_done_entry: got cpl=%b, need 1", wk_index_complete);
        end
        wk_hold = 1'b1;
      end
      if (c == 72) wk_hold = 1'b0;
    end
    n_cmp++;
    if ({block_ready, n_complete - cpl0} !== {1'b1, 32'd3}) begin
      n_fail++; $display("FAIL stall_pulse_len: got rdy=%b pulse_cycles=%0d, need rdy=1 pulse_cycles=3", block_ready, n_complete - cpl0);
    end
  endtask
`endif

  task automatic test_random_blocks();
    logic [511:0] blk;
    int waits;
    for (int n = 0; n < 100; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      blk = rand512();
      message_block = blk; block_valid = 1'b1; push_block(blk);
      @(negedge clock);
      block_valid = 1'b0;
      waits = 0;
      while (!block_ready && waits < 80) begin @(negedge clock); waits++; end
      n_cmp++;
      if (block_ready !== 1'b1) begin
        n_fail++; $display("FAIL random_timeout blk%0d: got rdy=%b after %0d cycles, need rdy=1", n, block_ready, waits);
        break;
      end
    end
    n_cmp++;
    if (sb.size() !== 0) begin
      n_fail++; $display("FAIL sb_leftover: got %0d pending rounds, need 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_ignore_valid();
    test_reset_mid();
    test_back_to_back();
`ifdef SHA256_WK_STALL_EN
    test_stall();
`endif
    test_random_blocks();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
